// File: rtl/toy_bus_ack_pipe_fifo.sv
// Ack-beat buffering stage behind the ToyBusAck arbiter: registered-count ready/valid
// breaks the out_rdy -> in_rdy path, plus a sticky check of tgt_id against LOCAL_ID.
module toy_bus_ack_pipe_fifo #(
  parameter int        DEPTH    = 2,
  parameter int        CNT_W    = 5,
  parameter logic [3:0] LOCAL_ID = 4'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic         in_opcode,
  input  logic [255:0] in_data,
  input  logic [9:0]   in_sideband,
  input  logic [3:0]   in_src_id,
  input  logic [3:0]   in_tgt_id,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic         out_opcode,
  output logic [255:0] out_data,
  output logic [9:0]   out_sideband,
  output logic [3:0]   out_src_id,
  output logic [3:0]   out_tgt_id,
  output logic [CNT_W-1:0] occupancy,
  output logic         misroute_err,
  input  logic         err_clr
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = 1 + 256 + 10 + 4 + 4;

  logic [BEAT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              push, pop;
  logic [BEAT_W-1:0] head;

  // Handshake decodes depend only on registered count, never on in_vld/out_rdy.
  assign in_rdy  = (count_q != CNT_W'(DEPTH));
  assign out_vld = (count_q != '0);
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    err_d   = err_q;
    if (err_clr) err_d = 1'b0;
    if (push && (in_tgt_id != LOCAL_ID)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Payload storage carries no reset; out_vld masking hides stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_opcode, in_data, in_sideband, in_src_id, in_tgt_id};
  end

  assign head = mem_q[rd_ptr_q] & {BEAT_W{out_vld}};
  assign {out_opcode, out_data, out_sideband, out_src_id, out_tgt_id} = head;
  assign occupancy    = count_q;
  assign misroute_err = err_q;

endmodule

// File: tb/tb_toy_bus_ack_pipe_fifo.sv
// Randomized + directed bench for toy_bus_ack_pipe_fifo against a queue-based model.
module tb_toy_bus_ack_pipe_fifo;
  localparam int DEPTH = 2;
  localparam int CNT_W = 5;

  typedef struct packed {
    logic         opcode;
    logic [255:0] data;
    logic [9:0]   sideband;
    logic [3:0]   src;
    logic [3:0]   tgt;
  } beat_t;

  logic clk = 0, rst_n = 0;
  logic in_vld = 0, in_rdy, in_opcode = 0, out_vld, out_rdy = 0, out_opcode;
  logic [255:0] in_data = '0, out_data;
  logic [9:0] in_sideband = '0, out_sideband;
  logic [3:0] in_src_id = '0, in_tgt_id = '0, out_src_id, out_tgt_id;
  logic [CNT_W-1:0] occupancy;
  logic misroute_err, err_clr = 0;

  int checks = 0, errors = 0;

  toy_bus_ack_pipe_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .LOCAL_ID(4'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_opcode(in_opcode), .in_data(in_data),
    .in_sideband(in_sideband), .in_src_id(in_src_id), .in_tgt_id(in_tgt_id),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_opcode(out_opcode), .out_data(out_data),
    .out_sideband(out_sideband), .out_src_id(out_src_id), .out_tgt_id(out_tgt_id),
    .occupancy(occupancy), .misroute_err(misroute_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of held beats plus the sticky flag.
  beat_t q[$];
  logic  m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      automatic bit acc = in_vld && (q.size() < DEPTH);
      automatic bit drn = out_rdy && (q.size() > 0);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{in_opcode, in_data, in_sideband, in_src_id, in_tgt_id});
      if (acc && in_tgt_id != 4'h0) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [274:0] act, input logic [274:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      automatic beat_t hd = (q.size() > 0) ? q[0] : beat_t'('0);
      chk("in_rdy", 275'(in_rdy), 275'(q.size() < DEPTH));
      chk("out_vld", 275'(out_vld), 275'(q.size() > 0));
      chk("occupancy", 275'(occupancy), 275'(q.size()));
      chk("out_beat", {out_opcode, out_data, out_sideband, out_src_id, out_tgt_id}, hd);
      chk("misroute_err", 275'(misroute_err), 275'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic vld, input logic [255:0] d, input logic [3:0] tgt,
                       input logic ordy, input logic clr);
    in_vld = vld; in_data = d; in_tgt_id = tgt; out_rdy = ordy; err_clr = clr;
    in_opcode = d[0]; in_sideband = d[9:0]; in_src_id = d[7:4];
  endtask

  initial begin
    // Reset then idle
    tick(); tick();
    rst_n = 1;
    tick();
    chk("rst_in_rdy", 275'(in_rdy), 275'(1));
    chk("rst_out_vld", 275'(out_vld), 275'(0));
    chk("rst_occ", 275'(occupancy), 275'(0));
    chk("rst_out_data", 275'(out_data), 275'(0));
    chk("rst_err", 275'(misroute_err), 275'(0));

    // Fill with out_rdy low, third beat held
    drive(1, 256'hA1, 0, 0, 0); tick();
    drive(1, 256'hB2, 0, 0, 0); tick();
    drive(1, 256'hC3, 0, 0, 0);
    chk("full_occ", 275'(occupancy), 275'(2));
    chk("full_in_rdy", 275'(in_rdy), 275'(0));
    chk("full_head", 275'(out_data), 275'(256'hA1));
    tick();
    chk("held_occ", 275'(occupancy), 275'(2));
    chk("held_head", 275'(out_data), 275'(256'hA1));
    drive(1, 256'hC3, 0, 1, 0); tick();
    chk("drain1_head", 275'(out_data), 275'(256'hB2));
    chk("drain1_occ", 275'(occupancy), 275'(1));
    tick();
    chk("drain2_head", 275'(out_data), 275'(256'hC3));
    chk("drain2_occ", 275'(occupancy), 275'(1));
    drive(0, 0, 0, 1, 0); tick();
    chk("drain3_occ", 275'(occupancy), 275'(0));

    // Streaming 7 beats with out_rdy high
    for (int i = 0; i < 7; i++) begin
      drive(1, 256'(8'h10 + i), 0, 1, 0); tick();
      chk("stream_occ", 275'(occupancy), 275'(1));
      chk("stream_head", 275'(out_data), 275'(8'h10 + i));
    end
    drive(0, 0, 0, 1, 0); tick();

    // Misroute flag
    drive(1, 256'h55, 4'h5, 0, 0); tick();
    chk("mis_set", 275'(misroute_err), 275'(1));
    chk("mis_fwd_tgt", 275'(out_tgt_id), 275'(5));
    drive(0, 0, 0, 1, 1); tick();
    chk("mis_clr", 275'(misroute_err), 275'(0));
    drive(1, 256'h66, 4'h5, 1, 1); tick();
    chk("mis_set_wins", 275'(misroute_err), 275'(1));
    drive(0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 1, 0); tick();

    // Reset mid-operation
    drive(1, 256'h77, 0, 0, 0); tick();
    drive(1, 256'h88, 0, 0, 0); tick();
    chk("pre_rst_occ", 275'(occupancy), 275'(2));
    drive(0, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    chk("async_out_vld", 275'(out_vld), 275'(0));
    chk("async_occ", 275'(occupancy), 275'(0));
    tick();
    rst_n = 1;
    drive(1, 256'hD4, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    chk("post_rst_head", 275'(out_data), 275'(256'hD4));
    drive(0, 0, 0, 1, 0); tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {8{$urandom}},
            ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
      tick();
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
